// File: rtl/riscv_core_amo_controller.sv
// riscv_core_amo_controller: sequences RISC-V AMO / LR / SC through a single-port memory
// using a four-state read/write FSM and tracks one doubleword-granule reservation.
`default_nettype none

module riscv_core_amo_controller (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_amo_valid,
   input  logic        i_amo_amo,
   input  logic        i_amo_lr,
   input  logic        i_amo_sc,
   input  logic [3:0]  i_amo_op,
   input  logic        i_amo_isword,
   input  logic [63:0] i_amo_addr,
   input  logic [63:0] i_amo_rs2,
   input  logic        i_amo_snoop_valid,
   input  logic [63:0] i_amo_snoop_addr,
   input  logic        i_amo_flush,
   input  logic        i_amo_mem_ready,
   input  logic [63:0] i_amo_mem_rdata,
   output logic        o_amo_mem_req,
   output logic        o_amo_mem_we,
   output logic [63:0] o_amo_mem_addr,
   output logic [63:0] o_amo_mem_wdata,
   output logic [1:0]  o_amo_mem_size,
   output logic [63:0] o_amo_result,
   output logic        o_amo_done,
   output logic        o_amo_stall,
   output logic        o_amo_misaligned
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state, state_nx;

   logic        lat_amo, lat_lr, lat_sc, lat_word;
   logic [3:0]  lat_op;
   logic [63:0] lat_addr, lat_rs2;
   logic [63:0] loaded;
   logic [63:0] result;
   logic        res_valid;
   logic [60:0] res_gran;
   logic        mis_pulse, mis_block;

   logic        one_kind, misalign, start, accept, mis_detect, sc_hit;
   logic        rd_fire, wr_fire, res_set, res_set_blocked, res_clr;
   logic [63:0] rdata_ext, amo_value;
   logic [63:0] a_u, b_s, b_u;
   logic        lt_s, lt_u;
   logic        unused_snoop_bits;

   assign unused_snoop_bits = ^i_amo_snoop_addr[2:0];

   // Exactly one of the three instruction kinds: odd parity but not all three.
   assign one_kind   = (i_amo_amo ^ i_amo_lr ^ i_amo_sc) & ~(i_amo_amo & i_amo_lr & i_amo_sc);
   assign misalign   = i_amo_isword ? (|i_amo_addr[1:0]) : (|i_amo_addr[2:0]);
   assign start      = (state == IDLE) & i_amo_valid & one_kind;
   assign accept     = start & ~misalign;
   assign mis_detect = start & misalign & ~mis_block;
   assign sc_hit     = res_valid & (res_gran == i_amo_addr[63:3]);
   assign rd_fire    = (state == RD) & i_amo_mem_ready;
   assign wr_fire    = (state == WR) & i_amo_mem_ready;

   assign rdata_ext = lat_word ? {{32{i_amo_mem_rdata[31]}}, i_amo_mem_rdata[31:0]}
                               : i_amo_mem_rdata;

   // Loaded value is already sign-extended for .W, so it doubles as the signed operand.
   assign a_u  = lat_word ? {32'h0, loaded[31:0]} : loaded;
   assign b_s  = lat_word ? {{32{lat_rs2[31]}}, lat_rs2[31:0]} : lat_rs2;
   assign b_u  = lat_word ? {32'h0, lat_rs2[31:0]} : lat_rs2;
   assign lt_s = $signed(loaded) < $signed(b_s);
   assign lt_u = a_u < b_u;

   always_comb begin
      amo_value = loaded;
      case (lat_op)
         4'd0:    amo_value = lat_rs2;
         4'd1:    amo_value = loaded + lat_rs2;
         4'd2:    amo_value = loaded ^ lat_rs2;
         4'd3:    amo_value = loaded & lat_rs2;
         4'd4:    amo_value = loaded | lat_rs2;
         4'd5:    amo_value = lt_s ? loaded : b_s;
         4'd6:    amo_value = lt_s ? b_s : loaded;
         4'd7:    amo_value = lt_u ? a_u : b_u;
         4'd8:    amo_value = lt_u ? b_u : a_u;
         default: amo_value = loaded;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (i_amo_amo | i_amo_lr) state_nx = RD;
               else if (sc_hit)          state_nx = WR;
               else                      state_nx = DONE;
            end
         end
         RD:      if (i_amo_mem_ready) state_nx = lat_amo ? WR : DONE;
         WR:      if (i_amo_mem_ready) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lat_amo  <= 1'b0;
         lat_lr   <= 1'b0;
         lat_sc   <= 1'b0;
         lat_word <= 1'b0;
         lat_op   <= 4'd0;
         lat_addr <= 64'd0;
         lat_rs2  <= 64'd0;
         loaded   <= 64'd0;
         result   <= 64'd0;
      end else begin
         if (accept) begin
            lat_amo  <= i_amo_amo;
            lat_lr   <= i_amo_lr;
            lat_sc   <= i_amo_sc;
            lat_word <= i_amo_isword;
            lat_op   <= i_amo_op;
            lat_addr <= i_amo_addr;
            lat_rs2  <= i_amo_rs2;
            if (i_amo_sc) result <= {63'd0, ~sc_hit};
         end
         if (rd_fire) begin
            loaded <= rdata_ext;
            result <= rdata_ext;
         end
      end
   end

   // A flush or matching snoop in the same cycle as the LR read beats the new reservation.
   assign res_set         = rd_fire & lat_lr;
   assign res_set_blocked = i_amo_flush
                          | (i_amo_snoop_valid & (i_amo_snoop_addr[63:3] == lat_addr[63:3]));
   assign res_clr         = i_amo_flush
                          | (i_amo_snoop_valid & (i_amo_snoop_addr[63:3] == res_gran))
                          | (wr_fire & lat_amo & (lat_addr[63:3] == res_gran))
                          | (accept & i_amo_sc);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         res_valid <= 1'b0;
         res_gran  <= 61'd0;
      end else if (res_set & ~res_set_blocked) begin
         res_valid <= 1'b1;
         res_gran  <= lat_addr[63:3];
      end else if (res_clr | res_set) begin
         res_valid <= 1'b0;
      end
   end

   // mis_block keeps a held misaligned request from pulsing again every cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mis_pulse <= 1'b0;
         mis_block <= 1'b0;
      end else begin
         mis_pulse <= mis_detect;
         if (!i_amo_valid)    mis_block <= 1'b0;
         else if (mis_detect) mis_block <= 1'b1;
      end
   end

   assign o_amo_mem_req    = (state == RD) | (state == WR);
   assign o_amo_mem_we     = (state == WR);
   assign o_amo_mem_addr   = o_amo_mem_req ? lat_addr : 64'd0;
   assign o_amo_mem_size   = o_amo_mem_req ? (lat_word ? 2'b10 : 2'b11) : 2'b00;
   assign o_amo_mem_wdata  = (state == WR) ? (lat_sc ? lat_rs2 : amo_value) : 64'd0;
   assign o_amo_result     = result;
   assign o_amo_done       = (state == DONE);
   assign o_amo_stall      = i_amo_valid & ~o_amo_done;
   assign o_amo_misaligned = mis_pulse;

endmodule

`default_nettype wire

// File: tb/tb_riscv_core_amo_controller.sv
// tb_riscv_core_amo_controller: directed and randomized atomic sequences checked against a
// transaction-level memory/reservation model kept in the bench.
`default_nettype none

module tb_riscv_core_amo_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        amo_valid, amo_amo, amo_lr, amo_sc, amo_isword;
   logic [3:0]  amo_op;
   logic [63:0] amo_addr, amo_rs2;
   logic        snoop_valid, flush, mem_ready;
   logic [63:0] snoop_addr, mem_rdata;
   logic        mem_req, mem_we, done, stall, misaligned;
   logic [63:0] mem_addr, mem_wdata, result;
   logic [1:0]  mem_size;

   int tests = 0;
   int fails = 0;

   logic [63:0] mem [logic [63:0]];
   bit          res_v = 1'b0;
   logic [60:0] res_g = '0;

   always #5 clk = ~clk;

   riscv_core_amo_controller dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_amo_valid(amo_valid), .i_amo_amo(amo_amo), .i_amo_lr(amo_lr), .i_amo_sc(amo_sc),
      .i_amo_op(amo_op), .i_amo_isword(amo_isword), .i_amo_addr(amo_addr), .i_amo_rs2(amo_rs2),
      .i_amo_snoop_valid(snoop_valid), .i_amo_snoop_addr(snoop_addr), .i_amo_flush(flush),
      .i_amo_mem_ready(mem_ready), .i_amo_mem_rdata(mem_rdata),
      .o_amo_mem_req(mem_req), .o_amo_mem_we(mem_we), .o_amo_mem_addr(mem_addr),
      .o_amo_mem_wdata(mem_wdata), .o_amo_mem_size(mem_size), .o_amo_result(result),
      .o_amo_done(done), .o_amo_stall(stall), .o_amo_misaligned(misaligned)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] mem_get(input logic [63:0] a);
      if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
      return mem[a];
   endfunction

   // Value the AMO must store, straight from the ISA definition of each operation.
   function automatic logic [63:0] model_wdata(input int op, input bit word,
                                               input logic [63:0] m, input logic [63:0] s);
      if (word) begin
         int unsigned ua = m[31:0];
         int unsigned ub = s[31:0];
         int sa = ua;
         int sb = ub;
         int unsigned r;
         case (op)
            0: r = ub;
            1: r = ua + ub;
            2: r = ua ^ ub;
            3: r = ua & ub;
            4: r = ua | ub;
            5: r = (sa < sb) ? ua : ub;
            6: r = (sa > sb) ? ua : ub;
            7: r = (ua < ub) ? ua : ub;
            8: r = (ua > ub) ? ua : ub;
            default: r = ua;
         endcase
         return {32'h0, r};
      end else begin
         longint unsigned ua = m;
         longint unsigned ub = s;
         longint sa = m;
         longint sb = s;
         case (op)
            0: return ub;
            1: return ua + ub;
            2: return ua ^ ub;
            3: return ua & ub;
            4: return ua | ub;
            5: return (sa < sb) ? ua : ub;
            6: return (sa > sb) ? ua : ub;
            7: return (ua < ub) ? ua : ub;
            8: return (ua > ub) ? ua : ub;
            default: return ua;
         endcase
      end
   endfunction

   // kind: 0 AMO, 1 LR, 2 SC, 3 no kind flag, 4 two kind flags.  Starts and ends on a negedge.
   task automatic run_op(input int kind, input int op, input bit word, input logic [63:0] addr,
                         input logic [63:0] rs2, input int rdy_pct, input int hold,
                         input bit flush_mid, output int cycles, output logic [63:0] got_res,
                         output logic [63:0] got_wd, output bit wrote);
      bit mis, hit, exp_rd, exp_wr, did_rd, did_wr, fin, any_req, any_done;
      logic [63:0] mval, ld, exp_res, exp_wd;
      int nreq, npulse;
      cycles = 0; got_res = '0; got_wd = '0; wrote = 1'b0;
      amo_amo = (kind == 0 || kind == 4);
      amo_lr  = (kind == 1 || kind == 4);
      amo_sc  = (kind == 2);
      amo_op = op[3:0]; amo_isword = word; amo_addr = addr; amo_rs2 = rs2;
      amo_valid = 1'b1;
      mis = word ? (addr[1:0] != 0) : (addr[2:0] != 0);
      if (kind >= 3 || mis) begin
         npulse = 0; any_req = 0; any_done = 0;
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (misaligned) npulse++;
            if (mem_req) any_req = 1;
            if (done) any_done = 1;
            chk("stall_held", stall, 1);
         end
         chk("mis_pulses", npulse, (kind >= 3) ? 0 : 1);
         chk("mis_no_req", any_req, 0);
         chk("mis_no_done", any_done, 0);
         amo_valid = 1'b0;
         @(negedge clk);
         return;
      end
      hit = (kind == 2) && res_v && (res_g == addr[63:3]);
      if (kind == 2) res_v = 1'b0;
      mval    = mem_get(addr);
      ld      = word ? {{32{mval[31]}}, mval[31:0]} : mval;
      exp_rd  = (kind != 2);
      exp_wr  = (kind == 0) || hit;
      exp_wd  = (kind == 2) ? rs2 : model_wdata(op, word, mval, rs2);
      exp_res = (kind == 2) ? {63'd0, !hit} : ld;
      fin = 0; did_rd = 0; did_wr = 0; nreq = 0;
      for (int c = 0; c < 300 && !fin; c++) begin
         @(negedge clk);
         cycles++;
         flush = flush_mid && (c == 0);
         if (flush) res_v = 1'b0;
         mem_ready = 1'b0;
         chk("stall", stall, {63'd0, !done});
         chk("misaligned_idle", misaligned, 0);
         if (done) begin
            chk("result", result, exp_res);
            chk("read_seen", did_rd, exp_rd);
            chk("write_seen", did_wr, exp_wr);
            got_res = result;
            fin = 1;
            amo_valid = 1'b0;
         end else if (mem_req) begin
            chk("mem_addr", mem_addr, addr);
            chk("mem_size", mem_size, word ? 2'b10 : 2'b11);
            if (!mem_we) begin
               chk("read_phase", exp_rd && !did_rd, 1);
            end else begin
               chk("write_phase", exp_wr && !did_wr && (did_rd || !exp_rd), 1);
               chk("wdata", word ? {32'h0, mem_wdata[31:0]} : mem_wdata,
                   word ? {32'h0, exp_wd[31:0]} : exp_wd);
               got_wd = mem_wdata;
            end
            if (nreq >= hold && $urandom_range(0, 99) < rdy_pct) begin
               mem_ready = 1'b1;
               if (!mem_we) begin
                  did_rd = 1;
                  mem_rdata = word ? {$urandom, mval[31:0]} : mval;
                  if (kind == 1) begin res_v = 1'b1; res_g = addr[63:3]; end
               end else begin
                  did_wr = 1; wrote = 1;
                  mem[addr] = word ? {mval[63:32], exp_wd[31:0]} : exp_wd;
                  if (kind == 0 && res_g == addr[63:3]) res_v = 1'b0;
               end
            end else begin
               mem_rdata = {$urandom, $urandom};
            end
            nreq++;
         end
      end
      if (!fin) begin
         chk("op_timeout", 0, 1);
         amo_valid = 1'b0;
      end
      flush = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      chk("done_one_cycle", done, 0);
   endtask

   task automatic idle_event(input bit is_flush, input logic [63:0] a);
      snoop_valid = !is_flush; snoop_addr = a; flush = is_flush;
      if (is_flush || (res_g == a[63:3])) res_v = 1'b0;
      @(negedge clk);
      snoop_valid = 1'b0; flush = 1'b0;
      chk("idle_req", mem_req, 0);
      chk("idle_done", done, 0);
   endtask

   initial begin
      int cyc, kind, r;
      logic [63:0] res, wd, a;
      bit wr;
      logic [63:0] pool [4];
      pool[0] = 64'h2000; pool[1] = 64'h2008; pool[2] = 64'h3000; pool[3] = 64'h3004;
      rst_n = 1'b0;
      amo_valid = 0; amo_amo = 0; amo_lr = 0; amo_sc = 0; amo_op = 0; amo_isword = 0;
      amo_addr = 0; amo_rs2 = 0; snoop_valid = 0; snoop_addr = 0; flush = 0;
      mem_ready = 0; mem_rdata = 0;
      #1;
      chk("rst_req", mem_req, 0);   chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0); chk("rst_wdata", mem_wdata, 0);
      chk("rst_size", mem_size, 0); chk("rst_result", result, 0);
      chk("rst_done", done, 0);     chk("rst_stall", stall, 0);
      chk("rst_mis", misaligned, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("pin_add_d", model_wdata(1, 0, 64'd5, 64'd7), 64'd12);
      chk("pin_min_w", model_wdata(5, 1, 64'hFFFF_FFFF, 64'd1), 64'hFFFF_FFFF);
      chk("pin_maxu_w", model_wdata(8, 1, 64'h8000_0000, 64'd1), 64'h8000_0000);

      mem[64'h1000] = 64'd5;
      run_op(0, 1, 0, 64'h1000, 64'd7, 100, 0, 0, cyc, res, wd, wr);
      chk("amoadd_cycles", cyc, 3); chk("amoadd_wdata", wd, 64'd12);
      chk("amoadd_result", res, 64'd5);

      mem[64'h1100] = 64'h0000_0000_FFFF_FFFF;
      run_op(0, 5, 1, 64'h1100, 64'd1, 100, 0, 0, cyc, res, wd, wr);
      chk("amomin_w_wdata", {32'h0, wd[31:0]}, 64'hFFFF_FFFF);
      chk("amomin_w_result", res, 64'hFFFF_FFFF_FFFF_FFFF);

      run_op(1, 0, 0, 64'h2000, 0, 100, 0, 0, cyc, res, wd, wr);
      run_op(2, 0, 0, 64'h2000, 64'hAB, 100, 0, 0, cyc, res, wd, wr);
      chk("sc1_wrote", wr, 1); chk("sc1_result", res, 0);
      run_op(2, 0, 0, 64'h2000, 64'hCD, 100, 0, 0, cyc, res, wd, wr);
      chk("sc2_wrote", wr, 0); chk("sc2_result", res, 1);

      run_op(1, 0, 1, 64'h3000, 0, 100, 0, 0, cyc, res, wd, wr);
      idle_event(0, 64'h3004);
      run_op(2, 0, 1, 64'h3000, 64'h55, 100, 0, 0, cyc, res, wd, wr);
      chk("sc_snooped_wrote", wr, 0); chk("sc_snooped_result", res, 1);

      run_op(0, 0, 1, 64'h1002, 64'h1, 100, 0, 0, cyc, res, wd, wr);
      run_op(0, 4, 0, 64'h1000, 64'hF0, 100, 5, 0, cyc, res, wd, wr);
      chk("hold_cycles", cyc, 8);

      // Reset during the write of an AMO to an unrelated granule must still kill the reservation.
      run_op(1, 0, 0, 64'h4000, 0, 100, 0, 0, cyc, res, wd, wr);
      amo_amo = 1; amo_lr = 0; amo_sc = 0; amo_op = 4'd1; amo_isword = 0;
      amo_addr = 64'h5000; amo_rs2 = 64'd3; amo_valid = 1;
      @(negedge clk);
      chk("rstwr_rd_req", {mem_req, mem_we}, 2'b10);
      mem_ready = 1; mem_rdata = 64'd9;
      @(negedge clk);
      chk("rstwr_wr_req", {mem_req, mem_we}, 2'b11);
      mem_ready = 0; rst_n = 1'b0;
      #1;
      chk("rstwr_req_drop", mem_req, 0);
      chk("rstwr_no_done", done, 0);
      amo_valid = 0;
      @(negedge clk);
      rst_n = 1'b1;
      res_v = 1'b0;
      @(negedge clk);
      chk("rstwr_idle_req", mem_req, 0);
      chk("rstwr_idle_done", done, 0);
      run_op(2, 0, 0, 64'h4000, 64'h77, 100, 0, 0, cyc, res, wd, wr);
      chk("rstwr_sc_result", res, 1);

      for (int i = 0; i < 250; i++) begin
         r = $urandom_range(0, 99);
         kind = (r < 35) ? 0 : (r < 55) ? 1 : (r < 85) ? 2 : (r < 92) ? 3 : 4;
         a = pool[$urandom_range(0, 3)];
         if ($urandom_range(0, 19) == 0) a = a + 64'($urandom_range(1, 3));
         run_op(kind, $urandom_range(0, 15), $urandom_range(0, 1), a, {$urandom, $urandom},
                $urandom_range(30, 100), 0, (kind == 0) && ($urandom_range(0, 3) == 0),
                cyc, res, wd, wr);
         r = $urandom_range(0, 9);
         if (r < 2)       idle_event(0, pool[$urandom_range(0, 3)] + 64'($urandom_range(0, 7)));
         else if (r == 2) idle_event(1, 64'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
